// File: rtl/inst_fetch_stage.sv
// IF stage of the pipelined TSC core: owns the PC, fetches over a readM/ready
// handshake, fills IF/ID, and handles ID stall and branch/jump redirect.
module inst_fetch_stage #(
  parameter int unsigned          WORD_SIZE = 16,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = 16'h0000,
  parameter logic [WORD_SIZE-1:0] NOP_INSTR = 16'hF03F
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 i_readM,
  output logic [WORD_SIZE-1:0] i_address,
  input  logic [WORD_SIZE-1:0] i_data,
  input  logic                 i_ready,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  output logic [WORD_SIZE-1:0] if_id_instr,
  output logic [WORD_SIZE-1:0] if_id_pc,
  output logic                 if_id_valid,
  output logic [3:0]           opcode,
  output logic [5:0]           func_code
);

  typedef enum logic [1:0] {IDLE, REQ, FULL, DRAIN} state_t;

  state_t               state, state_n;
  logic [WORD_SIZE-1:0] pc, pc_n, tgt, tgt_n, skid, skid_n;
  logic [WORD_SIZE-1:0] pc_plus, load_word;
  logic                 load;
  logic                 read_n;
  logic [WORD_SIZE-1:0] instr_n, ipc_n;
  logic                 valid_n;

  assign pc_plus   = pc + WORD_SIZE'(1);
  assign i_address = pc;
  assign opcode    = if_id_instr[WORD_SIZE-1 -: 4];
  assign func_code = if_id_instr[5:0];

  // Next-state, PC and IF/ID selection.
  always_comb begin
    state_n   = state;
    pc_n      = pc;
    tgt_n     = tgt;
    skid_n    = skid;
    load      = 1'b0;
    load_word = skid;
    case (state)
      IDLE: begin
        state_n = REQ;
        if (redirect) pc_n = redirect_pc;
      end
      REQ: begin
        if (i_ready) begin
          if (redirect) begin
            pc_n = redirect_pc;
          end else if (!stall) begin
            load      = 1'b1;
            load_word = i_data;
            pc_n      = pc_plus;
          end else begin
            skid_n  = i_data;
            state_n = FULL;
          end
        end else if (redirect) begin
          tgt_n   = redirect_pc;
          state_n = DRAIN;
        end
      end
      FULL: begin
        if (redirect) begin
          pc_n    = redirect_pc;
          state_n = REQ;
        end else if (!stall) begin
          load      = 1'b1;
          load_word = skid;
          pc_n      = pc_plus;
          state_n   = REQ;
        end
      end
      DRAIN: begin
        // The in-flight word is discarded; the newest target wins.
        if (i_ready) begin
          pc_n    = redirect ? redirect_pc : tgt;
          state_n = REQ;
        end else if (redirect) begin
          tgt_n = redirect_pc;
        end
      end
      default: state_n = IDLE;
    endcase

    read_n  = (state_n == REQ) || (state_n == DRAIN);
    instr_n = NOP_INSTR;
    ipc_n   = '0;
    valid_n = 1'b0;
    if (redirect) begin
      instr_n = NOP_INSTR;
    end else if (stall) begin
      instr_n = if_id_instr;
      ipc_n   = if_id_pc;
      valid_n = if_id_valid;
    end else if (load) begin
      instr_n = load_word;
      ipc_n   = pc_plus;
      valid_n = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      tgt         <= '0;
      skid        <= '0;
      i_readM     <= 1'b0;
      if_id_instr <= NOP_INSTR;
      if_id_pc    <= '0;
      if_id_valid <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      tgt         <= tgt_n;
      skid        <= skid_n;
      i_readM     <= read_n;
      if_id_instr <= instr_n;
      if_id_pc    <= ipc_n;
      if_id_valid <= valid_n;
    end
  end

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Directed bench for inst_fetch_stage with a latency-configurable instruction
// memory model (mem[n] = 16'h1000 + n).
module tb_inst_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_readM;
  logic [15:0] i_address;
  logic [15:0] i_data = '0;
  logic        i_ready = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic [15:0] if_id_instr, if_id_pc;
  logic        if_id_valid;
  logic [3:0]  opcode;
  logic [5:0]  func_code;

  int vectors = 0;
  int miscompares = 0;
  int lat = 1;
  int cnt = 0;

  inst_fetch_stage dut (
    .clk(clk), .reset(reset), .i_readM(i_readM), .i_address(i_address),
    .i_data(i_data), .i_ready(i_ready), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
    .if_id_valid(if_id_valid), .opcode(opcode), .func_code(func_code)
  );

  always #5 clk = ~clk;

  // Memory responder: ready in the lat-th cycle of each request.
  task automatic mem_update();
    if (!i_readM || reset) begin
      cnt = 0;
      i_ready = 1'b0;
    end else begin
      i_ready = (cnt == lat - 1);
      i_data  = 16'h1000 + i_address;
      cnt     = i_ready ? 0 : cnt + 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    mem_update();
  endtask

  task automatic apply_reset(input int latency);
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; lat = latency;
    mem_update();
    tick(); tick();
    reset = 1'b0;
    mem_update();
  endtask

  task automatic test_reset();
    logic [49:0] got, exp;
    apply_reset(1);
    reset = 1'b1;
    tick();
    got = {i_readM, i_address, if_id_instr, if_id_pc, if_id_valid};
    exp = {1'b0, 16'h0000, 16'hF03F, 16'h0000, 1'b0};
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL reset_state got %h exp %h", got, exp); end
    vectors++;
    if ({opcode, func_code} !== {4'hF, 6'h3F}) begin
      miscompares++; $display("FAIL reset_decode got %h/%h exp f/3f", opcode, func_code);
    end
    reset = 1'b0;
    mem_update();
  endtask

  task automatic test_one_cycle_mem();
    logic [48:0] got, exp;
    apply_reset(1);
    tick();
    vectors++;
    if ({i_readM, i_address, if_id_valid} !== {1'b1, 16'h0000, 1'b0}) begin
      miscompares++; $display("FAIL first_req got %b %h %b exp 1 0000 0", i_readM, i_address, if_id_valid);
    end
    for (int k = 2; k <= 6; k++) begin
      tick();
      got = {i_address, if_id_instr, if_id_pc, if_id_valid};
      exp = {16'(k - 1), 16'(16'h1000 + k - 2), 16'(k - 1), 1'b1};
      vectors++;
      if (got !== exp) begin miscompares++; $display("FAIL stream_k%0d got %h exp %h", k, got, exp); end
    end
  endtask

  task automatic test_stall();
    logic [49:0] got, exp;
    apply_reset(1);
    repeat (6) tick();
    stall = 1'b1;
    for (int k = 7; k <= 10; k++) begin
      tick();
      got = {i_readM, i_address, if_id_instr, if_id_pc, if_id_valid};
      exp = {1'b0, 16'h0005, 16'h1004, 16'h0005, 1'b1};
      vectors++;
      if (got !== exp) begin miscompares++; $display("FAIL stall_hold_k%0d got %h exp %h", k, got, exp); end
    end
    stall = 1'b0;
    tick();
    got = {i_readM, i_address, if_id_instr, if_id_pc, if_id_valid};
    exp = {1'b1, 16'h0006, 16'h1005, 16'h0006, 1'b1};
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL stall_release got %h exp %h", got, exp); end
    tick();
    got = {i_readM, i_address, if_id_instr, if_id_pc, if_id_valid};
    exp = {1'b1, 16'h0007, 16'h1006, 16'h0007, 1'b1};
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL stall_resume got %h exp %h", got, exp); end
  endtask

  task automatic test_three_cycle_mem();
    logic [48:0] got, exp;
    logic [15:0] ei;
    logic        ev;
    apply_reset(3);
    for (int t = 1; t <= 10; t++) begin
      tick();
      ev = (t >= 4) && ((t - 1) % 3 == 0);
      ei = ev ? 16'(16'h1000 + (t - 4) / 3) : 16'hF03F;
      got = {i_address, if_id_instr, if_id_pc, if_id_valid};
      exp = {16'((t - 1) / 3), ei, ev ? 16'((t - 1) / 3) : 16'h0000, ev};
      vectors++;
      if (got !== exp) begin miscompares++; $display("FAIL lat3_t%0d got %h exp %h", t, got, exp); end
      vectors++;
      if ({opcode, func_code} !== {ei[15:12], ei[5:0]}) begin
        miscompares++; $display("FAIL lat3_decode_t%0d got %h/%h exp %h/%h", t, opcode, func_code, ei[15:12], ei[5:0]);
      end
    end
  endtask

  task automatic test_redirect_drain();
    logic [49:0] got, exp;
    apply_reset(3);
    repeat (22) tick();
    vectors++;
    if ({i_address, if_id_instr} !== {16'h0007, 16'h1006}) begin
      miscompares++; $display("FAIL drain_setup got %h %h exp 0007 1006", i_address, if_id_instr);
    end
    redirect = 1'b1; redirect_pc = 16'h0040;
    tick();
    redirect = 1'b0;
    got = {i_readM, i_address, if_id_instr, if_id_pc, if_id_valid};
    exp = {1'b1, 16'h0007, 16'hF03F, 16'h0000, 1'b0};
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL drain_bubble got %h exp %h", got, exp); end
    tick();
    vectors++;
    if ({i_readM, i_address} !== {1'b1, 16'h0007}) begin
      miscompares++; $display("FAIL drain_hold got %b %h exp 1 0007", i_readM, i_address);
    end
    tick();
    vectors++;
    if ({i_address, if_id_valid} !== {16'h0040, 1'b0}) begin
      miscompares++; $display("FAIL drain_target got %h %b exp 0040 0", i_address, if_id_valid);
    end
    repeat (3) tick();
    got = {i_readM, i_address, if_id_instr, if_id_pc, if_id_valid};
    exp = {1'b1, 16'h0041, 16'h1040, 16'h0041, 1'b1};
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL drain_first_word got %h exp %h", got, exp); end
  endtask

  task automatic test_redirect_stall_mix();
    logic [49:0] got, exp;
    apply_reset(1);
    repeat (6) tick();
    stall = 1'b1;
    tick();
    redirect = 1'b1; redirect_pc = 16'h0020;
    tick();
    redirect = 1'b0; stall = 1'b0;
    got = {i_readM, i_address, if_id_instr, if_id_pc, if_id_valid};
    exp = {1'b1, 16'h0020, 16'hF03F, 16'h0000, 1'b0};
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL full_redirect got %h exp %h", got, exp); end
    tick();
    got = {i_readM, i_address, if_id_instr, if_id_pc, if_id_valid};
    exp = {1'b1, 16'h0021, 16'h1020, 16'h0021, 1'b1};
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL full_redirect_word got %h exp %h", got, exp); end

    apply_reset(3);
    tick();
    redirect = 1'b1; redirect_pc = 16'h0030;
    tick();
    redirect_pc = 16'h0050;
    tick();
    redirect = 1'b0;
    vectors++;
    if ({i_readM, i_address} !== {1'b1, 16'h0000}) begin
      miscompares++; $display("FAIL double_redirect_hold got %b %h exp 1 0000", i_readM, i_address);
    end
    tick();
    vectors++;
    if ({i_address, if_id_valid} !== {16'h0050, 1'b0}) begin
      miscompares++; $display("FAIL double_redirect_target got %h %b exp 0050 0", i_address, if_id_valid);
    end
    repeat (3) tick();
    vectors++;
    if ({if_id_instr, if_id_pc, if_id_valid} !== {16'h1050, 16'h0051, 1'b1}) begin
      miscompares++; $display("FAIL double_redirect_word got %h %h %b exp 1050 0051 1", if_id_instr, if_id_pc, if_id_valid);
    end
  endtask

  task automatic test_wrap_and_reset_mid_drain();
    logic [49:0] got, exp;
    apply_reset(1);
    tick();
    redirect = 1'b1; redirect_pc = 16'hFFFF;
    tick();
    redirect = 1'b0;
    vectors++;
    if ({i_address, if_id_valid} !== {16'hFFFF, 1'b0}) begin
      miscompares++; $display("FAIL wrap_target got %h %b exp ffff 0", i_address, if_id_valid);
    end
    tick();
    got = {i_readM, i_address, if_id_instr, if_id_pc, if_id_valid};
    exp = {1'b1, 16'h0000, 16'h0FFF, 16'h0000, 1'b1};
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL pc_wrap got %h exp %h", got, exp); end

    apply_reset(3);
    tick();
    redirect = 1'b1; redirect_pc = 16'h0080;
    tick();
    redirect = 1'b0;
    vectors++;
    if (i_readM !== 1'b1) begin miscompares++; $display("FAIL drain_before_reset got %b exp 1", i_readM); end
    #2 reset = 1'b1;
    #1;
    got = {i_readM, i_address, if_id_instr, if_id_pc, if_id_valid};
    exp = {1'b0, 16'h0000, 16'hF03F, 16'h0000, 1'b0};
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL async_reset got %h exp %h", got, exp); end
    mem_update();
    tick();
    reset = 1'b0;
    mem_update();
    tick();
    vectors++;
    if ({i_readM, i_address} !== {1'b1, 16'h0000}) begin
      miscompares++; $display("FAIL restart got %b %h exp 1 0000", i_readM, i_address);
    end
  endtask

  initial begin
    test_reset();
    test_one_cycle_mem();
    test_stall();
    test_three_cycle_mem();
    test_redirect_drain();
    test_redirect_stall_mix();
    test_wrap_and_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
